// File: rtl/mvm_control.sv
// Control FSM for a small matrix-vector multiply engine.
//
// A job streams ROWS*COLS matrix bytes, then COLS vector bytes, over a shared
// data bus into external memories. The FSM then computes one row at a time:
// ISSUE walks the row's addresses, DRAIN covers the one-cycle memory read
// latency, OUTPUT loads the MAC result register, and WAIT_OUT holds the result
// until downstream accepts it. After the last row it returns to LOAD_M for a
// new job.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   s_valid / s_ready  upstream byte handshake (byte carried on the shared bus)
//   wren_M, addr_M     matrix memory write strobe / address
//   wren_X, addr_X     vector memory write strobe / address
//   clr_acc            clears the MAC accumulator (first ISSUE cycle of a row)
//   en_out             loads the accumulator into the MAC result register
//   m_valid / m_ready  downstream result handshake
//   busy               high in every state except IDLE
module mvm_control #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       wren_M,
  output logic       wren_X,
  output logic [3:0] addr_M,
  output logic [1:0] addr_X,
  output logic       clr_acc,
  output logic       en_out,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadM,
    StLoadX,
    StIssue,
    StDrain,
    StOutput,
    StWaitOut
  } state_e;

  // Terminal counts are compared against count-1 so a 16-entry matrix never
  // needs a fifth counter bit.
  localparam logic [3:0] LastM   = 4'(ROWS * COLS - 1);
  localparam logic [3:0] LastX   = 4'(COLS - 1);
  localparam logic [3:0] ColsW   = 4'(COLS);
  localparam logic [1:0] LastRow = 2'(ROWS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;  // load count in LOAD_M/LOAD_X, k in ISSUE
  logic [1:0] row_q, row_d;

  logic [3:0] issue_addr;
  assign issue_addr = ({2'b00, row_q} * ColsW) + cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Outputs decode registered state only; s_valid reaches the write strobes
  // and m_ready reaches the state advance, nothing else is combinational.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    s_ready = 1'b0;
    wren_M  = 1'b0;
    wren_X  = 1'b0;
    addr_M  = 4'd0;
    addr_X  = 2'd0;
    clr_acc = 1'b0;
    en_out  = 1'b0;
    m_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d   = 4'd0;
        row_d   = 2'd0;
        state_d = StLoadM;
      end

      StLoadM: begin
        s_ready = 1'b1;
        addr_M  = cnt_q;
        if (s_valid) begin
          wren_M = 1'b1;
          if (cnt_q == LastM) begin
            cnt_d   = 4'd0;
            state_d = StLoadX;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      StLoadX: begin
        s_ready = 1'b1;
        addr_X  = cnt_q[1:0];
        if (s_valid) begin
          wren_X = 1'b1;
          if (cnt_q == LastX) begin
            cnt_d   = 4'd0;
            row_d   = 2'd0;
            state_d = StIssue;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      StIssue: begin
        addr_M  = issue_addr;
        addr_X  = cnt_q[1:0];
        clr_acc = (cnt_q == 4'd0);
        if (cnt_q == LastX) begin
          cnt_d   = 4'd0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // Last product arrives from memory this cycle and is accumulated.
      StDrain: begin
        state_d = StOutput;
      end

      StOutput: begin
        en_out  = 1'b1;
        state_d = StWaitOut;
      end

      StWaitOut: begin
        m_valid = 1'b1;
        if (m_ready) begin
          cnt_d = 4'd0;
          if (row_q == LastRow) begin
            row_d   = 2'd0;
            state_d = StLoadM;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = StIssue;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mvm_control.sv
// Bench for mvm_control: models the matrix/vector memories (1-cycle read) and
// a MAC around the controller, checks a cycle table for the first job, and
// scoreboards every accepted row result against dot products of the fed data.
module tb_mvm_control;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int NM   = ROWS * COLS;
  localparam int NB   = NM + COLS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready, wren_M, wren_X, clr_acc, en_out, m_valid, busy;
  logic [3:0] addr_M;
  logic [1:0] addr_X;

  always #5 clk = ~clk;

  mvm_control #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .wren_M (wren_M),
    .wren_X (wren_X),
    .addr_M (addr_M),
    .addr_X (addr_X),
    .clr_acc(clr_acc),
    .en_out (en_out),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy   (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Upstream byte source: one job's bytes, matrix row-major then vector.
  logic [7:0] feed [NB];
  int         feed_idx = 0;
  logic [7:0] data_in;
  assign data_in = feed[feed_idx];

  always @(posedge clk) begin
    if (reset) feed_idx <= 0;
    else if (s_valid && s_ready) feed_idx <= (feed_idx == NB - 1) ? 0 : feed_idx + 1;
  end

  // Memories with registered read, and the MAC datapath being controlled.
  logic [7:0]  mem_m [16];
  logic [7:0]  mem_x [4];
  logic [7:0]  rd_m, rd_x;
  logic        clr_d = 1'b0;
  logic [15:0] acc = '0;
  logic [15:0] data_out = '0;

  always @(posedge clk) begin
    if (wren_M) mem_m[addr_M] <= data_in;
    if (wren_X) mem_x[addr_X] <= data_in;
    rd_m     <= mem_m[addr_M];
    rd_x     <= mem_x[addr_X];
    clr_d    <= clr_acc;
    acc      <= (clr_d ? 16'd0 : acc) + 16'(rd_m) * 16'(rd_x);
    if (en_out) data_out <= acc;
  end

  // Scoreboard: expected row results queued when a job's data is defined.
  logic [15:0] exp_q [$];

  task automatic push_job();
    for (int r = 0; r < ROWS; r++) begin
      int sum = 0;
      for (int k = 0; k < COLS; k++) sum += int'(feed[r * COLS + k]) * int'(feed[NM + k]);
      exp_q.push_back(16'(sum));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", int'(data_out), -1);
      else chk("row_result", int'(data_out), int'(exp_q.pop_front()));
    end
  end

  // Row latency: first ISSUE cycle (clr_acc) to m_valid rising.
  int   cyc = 0;
  int   issue_cyc = 0;
  logic mv_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clr_acc) issue_cyc = cyc;
    if (m_valid && !mv_prev) chk("row_latency", cyc - issue_cyc, COLS + 2);
    mv_prev = m_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       s_valid;
    logic       m_ready;
    logic       s_ready, wren_M, wren_X;
    logic [3:0] addr_M;
    logic [1:0] addr_X;
    logic       clr_acc, en_out, m_valid, busy;
  } vec_t;

  vec_t vec [19];

  function automatic logic [12:0] outs();
    return {s_ready, wren_M, wren_X, addr_M, addr_X, clr_acc, en_out, m_valid, busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         acc_cnt;
    int         wcnt;
    logic       seen;
    logic [15:0] held;

    // Job 1 cycle table, starting with the IDLE cycle after reset release.
    for (int i = 0; i < 19; i++) begin
      vec[i] = '{s_valid: 1'b1, m_ready: 1'b1, s_ready: 1'b0, wren_M: 1'b0, wren_X: 1'b0,
                 addr_M: 4'd0, addr_X: 2'd0, clr_acc: 1'b0, en_out: 1'b0, m_valid: 1'b0,
                 busy: (i != 0)};
      if (i >= 1 && i <= 9) begin
        vec[i].s_ready = 1'b1; vec[i].wren_M = 1'b1; vec[i].addr_M = 4'(i - 1);
      end
      if (i >= 10 && i <= 12) begin
        vec[i].s_ready = 1'b1; vec[i].wren_X = 1'b1; vec[i].addr_X = 2'(i - 10);
      end
      if (i >= 13 && i <= 15) begin
        vec[i].addr_M = 4'(i - 13); vec[i].addr_X = 2'(i - 13); vec[i].clr_acc = (i == 13);
      end
      if (i == 17) vec[i].en_out = 1'b1;
      if (i == 18) vec[i].m_valid = 1'b1;
    end

    for (int i = 0; i < NM; i++) feed[i] = 8'(i + 1);
    for (int k = 0; k < COLS; k++) feed[NM + k] = 8'(k + 1);
    push_job();  // 14, 32, 50

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs_zero", int'(outs()), 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      s_valid = vec[i].s_valid;
      m_ready = vec[i].m_ready;
      @(negedge clk);
      chk($sformatf("vec[%0d]", i), int'(outs()),
          int'({vec[i].s_ready, vec[i].wren_M, vec[i].wren_X, vec[i].addr_M, vec[i].addr_X,
                vec[i].clr_acc, vec[i].en_out, vec[i].m_valid, vec[i].busy}));
      step();
    end

    // Remaining job 1 rows; prepare job 2 (M all 2, X all 1).
    s_valid = 1'b0;
    for (int i = 0; i < NB; i++) feed[i] = (i < NM) ? 8'd2 : 8'd1;
    push_job();
    acc_cnt = 0;
    for (int t = 0; t < 100 && acc_cnt < 2; t++) begin
      @(negedge clk);
      if (m_valid) acc_cnt++;
      step();
    end
    chk("job1_rows_accepted", acc_cnt, 2);
    @(negedge clk);
    chk("reload_s_ready", int'(s_ready), 1);
    chk("reload_addr_M", int'(addr_M), 0);
    step();

    // Job 2 matrix load with s_valid toggling.
    wcnt = 0;
    for (int t = 0; t < 40 && wcnt < NM; t++) begin
      s_valid = (t % 2 == 0);
      @(negedge clk);
      chk("toggle_strobe", int'(wren_M), int'(s_valid));
      if (wren_M) begin
        chk("toggle_addr", int'(addr_M), wcnt);
        wcnt++;
      end
      step();
    end
    chk("toggle_write_count", wcnt, NM);
    s_valid = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      @(negedge clk);
      chk("loadx_strobe", int'({wren_M, wren_X}), 1);
      chk("loadx_addr", int'(addr_X), j);
      step();
    end
    s_valid = 1'b0;

    // Back-pressure on the first row result.
    m_ready = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("job2_mvalid_seen", int'(seen), 1);
    held = data_out;
    chk("job2_row0_value", int'(held), 6);
    for (int t = 0; t < 4; t++) begin
      step();
      @(negedge clk);
      chk("hold_m_valid", int'(m_valid), 1);
      chk("hold_data_out", int'(data_out), int'(held));
      chk("hold_no_issue", int'({clr_acc, en_out, s_ready, addr_M}), 0);
    end
    step();
    m_ready = 1'b1;
    acc_cnt = 0;
    for (int t = 0; t < 100 && acc_cnt < 3; t++) begin
      @(negedge clk);
      if (m_valid) acc_cnt++;
      step();
    end
    chk("job2_rows_accepted", acc_cnt, 3);

    // Job 3: reset after 5 matrix bytes, then a full reload.
    for (int i = 0; i < NM; i++) feed[i] = 8'(NM - i);
    feed[NM] = 8'd2; feed[NM + 1] = 8'd0; feed[NM + 2] = 8'd3;
    s_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("partial_addr", int'({wren_M, addr_M}), 16 + t);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midload_reset_outputs", int'(outs()), 0);
    step();
    @(negedge clk);
    chk("restart_addr_M", int'({wren_M, s_ready, addr_M}), 48);
    push_job();  // 39, 24, 9
    acc_cnt = 0;
    for (int t = 0; t < 100 && acc_cnt < 3; t++) begin
      @(negedge clk);
      if (m_valid) acc_cnt++;
      step();
    end
    chk("job3_rows_accepted", acc_cnt, 3);
    s_valid = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
